spi_slave: RTL and testbench



---
 rtl/spi_slave.sv | 215 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: memory-mapped SPI mode-0 slave (MSB first, 8-bit frames) for the TRSQ8 bus.
// Optional receive interrupt and CTRL.RXIE are enabled by defining SPI_SLAVE_IRQ_EN.
module spi_slave #(
  parameter logic [7:0] BASE_ADDR = 8'h84,
  parameter logic [7:0] DUMMY_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe,
  output logic       irq
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic       r_mosi_s1, r_mosi_s2;
  logic       r_ss_s1, r_ss_s2, r_ss_s3;
  logic       r_en, r_rxie;
  logic [7:0] r_dummy, r_txdata, r_rxdata, r_tx_sh;
  logic [6:0] r_rx_sh;
  logic [2:0] r_bitcnt;
  logic       r_tx_full, r_rx_full, r_overrun, r_abort, r_miso_oe, r_irq;

  logic       w_sclk_rise, w_sclk_fall, w_ss_fall, w_hit;
  logic       w_wr_data, w_wr_stat, w_wr_ctrl, w_wr_dummy, w_rd_data;
  logic       w_load, w_shift_rx, w_shift_tx, w_abort_set;
  logic       w_byte_done, w_rx_accept, w_ovr_set;
  logic [7:0] w_rx_byte, w_tx_load_val, w_status, w_ctrl;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_ss_fall   = ~r_ss_s2 & r_ss_s3;

  assign w_hit      = (addr[7:2] == BASE_ADDR[7:2]);
  assign w_wr_data  = w_hit & wr_en & (addr[1:0] == 2'd0);
  assign w_wr_stat  = w_hit & wr_en & (addr[1:0] == 2'd1);
  assign w_wr_ctrl  = w_hit & wr_en & (addr[1:0] == 2'd2);
  assign w_wr_dummy = w_hit & wr_en & (addr[1:0] == 2'd3);
  assign w_rd_data  = w_hit & rd_en & (addr[1:0] == 2'd0);

  assign w_rx_byte     = {r_rx_sh, r_mosi_s2};
  assign w_tx_load_val = r_tx_full ? r_txdata : r_dummy;
  // A same-cycle DATA read frees the holding register for the incoming byte.
  assign w_byte_done   = w_shift_rx & (r_bitcnt == 3'd7);
  assign w_rx_accept   = w_byte_done & (~r_rx_full | w_rd_data);
  assign w_ovr_set     = w_byte_done & ~w_rx_accept;

  assign w_status = {2'b00, r_ss_s2, (r_state == ST_ACTIVE), r_abort, r_overrun, r_tx_full, r_rx_full};
`ifdef SPI_SLAVE_IRQ_EN
  assign w_ctrl = {6'b000000, r_rxie, r_en};
`else
  assign w_ctrl = {7'b0000000, r_en};
`endif

  assign miso    = r_tx_sh[7];
  assign miso_oe = r_miso_oe;
  assign irq     = r_irq;

  // Input synchronisers plus the extra flops used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_s3 <= 1'b0;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
      r_ss_s1   <= 1'b1; r_ss_s2   <= 1'b1; r_ss_s3   <= 1'b1;
    end else begin
      r_sclk_s1 <= sclk;      r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= mosi;      r_mosi_s2 <= r_mosi_s1;
      r_ss_s1   <= ss_n;      r_ss_s2   <= r_ss_s1;   r_ss_s3   <= r_ss_s2;
    end
  end

  // Next-state and per-cycle shift/load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift_rx  = 1'b0;
    w_shift_tx  = 1'b0;
    w_abort_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en && w_ss_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (r_ss_s2 || !r_en) begin
          w_state_nxt = ST_IDLE;
          w_abort_set = r_ss_s2 && (r_bitcnt != 3'd0);
        end else begin
          w_shift_rx = w_sclk_rise;
          if (w_sclk_fall && (r_bitcnt == 3'd0)) begin
            w_load = 1'b1;
          end else begin
            w_shift_tx = w_sclk_fall;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, shifters, bit counter and output enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_tx_sh   <= 8'h00;
      r_rx_sh   <= 7'h00;
      r_bitcnt  <= 3'd0;
      r_miso_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_miso_oe <= (w_state_nxt == ST_ACTIVE);
      if (w_load) begin
        r_tx_sh <= w_tx_load_val;
      end else if (w_shift_tx) begin
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      end else if (w_state_nxt == ST_IDLE) begin
        r_tx_sh <= 8'h00;
      end
      if (r_state == ST_IDLE) begin
        r_bitcnt <= 3'd0;
      end else if (w_shift_rx) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_shift_rx) begin
        r_rx_sh <= w_rx_byte[6:0];
      end
    end
  end

  // CPU-visible registers; hardware sets take priority over CPU clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= 1'b0;
      r_dummy   <= DUMMY_RST;
      r_txdata  <= 8'h00;
      r_tx_full <= 1'b0;
      r_rxdata  <= 8'h00;
      r_rx_full <= 1'b0;
      r_overrun <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      if (w_wr_ctrl)  r_en    <= din[0];
      if (w_wr_dummy) r_dummy <= din;
      if (w_wr_data)  r_txdata <= din;
      if (w_wr_data) begin
        r_tx_full <= 1'b1;
      end else if (w_load && r_tx_full) begin
        r_tx_full <= 1'b0;
      end
      if (w_rx_accept) r_rxdata <= w_rx_byte;
      if (w_rx_accept) begin
        r_rx_full <= 1'b1;
      end else if (w_rd_data) begin
        r_rx_full <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (w_wr_stat && din[2]) begin
        r_overrun <= 1'b0;
      end
      if (w_abort_set) begin
        r_abort <= 1'b1;
      end else if (w_wr_stat && din[3]) begin
        r_abort <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  // Receive interrupt enable and registered interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxie <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_rxie <= din[1];
      r_irq <= r_rxie & r_rx_full;
    end
  end
`else
  assign r_rxie = 1'b0;
  assign r_irq  = 1'b0;
`endif

  // Combinational read mux.
  always_comb begin
    dout = 8'h00;
    if (w_hit) begin
      case (addr[1:0])
        2'd0:    dout = r_rxdata;
        2'd1:    dout = w_status;
        2'd2:    dout = w_ctrl;
        2'd3:    dout = r_dummy;
        default: dout = 8'h00;
      endcase
    end else begin
      dout = 8'h00;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave, with a bit-banged mode-0 SPI master.
// Covers both builds; the interrupt test adapts to SPI_SLAVE_IRQ_EN.
module tb_spi_slave;

  localparam logic [7:0] A_DATA  = 8'h84;
  localparam logic [7:0] A_STAT  = 8'h85;
  localparam logic [7:0] A_CTRL  = 8'h86;
  localparam logic [7:0] A_DUMMY = 8'h87;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] addr, din, dout;
  logic       wr_en, rd_en, sclk, mosi, ss_n, miso, miso_oe, irq;
  int         checks = 0;
  int         errors = 0;

  spi_slave #(.BASE_ADDR(8'h84), .DUMMY_RST(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .wr_en(wr_en), .rd_en(rd_en), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_peek(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    #1 d = dout;
  endtask

  task automatic data_pop(output logic [7:0] d);
    @(negedge clk);
    addr = A_DATA; rd_en = 1'b1;
    #1 d = dout;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Mode-0 master: drive mosi after each fall, sample miso just before each rise.
  task automatic spi_frame(input logic [15:0] txw, input int nbits,
                           output logic [15:0] rxw, output logic oe);
    rxw = 16'h0000;
    @(negedge clk);
    ss_n = 1'b0;
    wait_clk(HALF);
    oe = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      mosi = txw[15-i];
      wait_clk(HALF);
      rxw = {rxw[14:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset_n = 1'b0; addr = 8'h00; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(2);
    bus_peek(A_DATA, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", v); end
    bus_peek(A_STAT, v);  checks++; if (v !== 8'h20) begin errors++; $display("FAIL reset_status got %h exp 20", v); end
    bus_peek(A_CTRL, v);  checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", v); end
    bus_peek(A_DUMMY, v); checks++; if (v !== 8'hFF) begin errors++; $display("FAIL reset_dummy got %h exp ff", v); end
    checks++; if ({miso, miso_oe, irq} !== 3'b000) begin errors++; $display("FAIL reset_outs got %b exp 000", {miso, miso_oe, irq}); end
  endtask

  task automatic test_decode();
    logic [7:0] v;
    bus_write(8'h8B, 8'h00);
    bus_peek(A_DUMMY, v); checks++; if (v !== 8'hFF) begin errors++; $display("FAIL decode_miss got %h exp ff", v); end
  endtask

  task automatic test_basic();
    logic [7:0] v; logic [15:0] rx; logic oe;
    bus_write(A_CTRL, 8'h01);
    bus_write(A_DATA, 8'hA5);
    bus_peek(A_STAT, v); checks++; if (v !== 8'h22) begin errors++; $display("FAIL basic_txfull got %h exp 22", v); end
    spi_frame({8'h3C, 8'h00}, 8, rx, oe);
    checks++; if (rx[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h exp a5", rx[7:0]); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL basic_oe got %b exp 1", oe); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_idle got %b exp 0", miso_oe); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h21) begin errors++; $display("FAIL basic_status got %h exp 21", v); end
    data_pop(v); checks++; if (v !== 8'h3C) begin errors++; $display("FAIL basic_rxdata got %h exp 3c", v); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h20) begin errors++; $display("FAIL basic_rxclr got %h exp 20", v); end
  endtask

  task automatic test_overrun();
    logic [7:0] v; logic [15:0] rx; logic oe;
    spi_frame({8'h11, 8'h00}, 8, rx, oe);
    checks++; if (rx[7:0] !== 8'hFF) begin errors++; $display("FAIL ovr_dummy1 got %h exp ff", rx[7:0]); end
    spi_frame({8'h22, 8'h00}, 8, rx, oe);
    checks++; if (rx[7:0] !== 8'hFF) begin errors++; $display("FAIL ovr_dummy2 got %h exp ff", rx[7:0]); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h25) begin errors++; $display("FAIL ovr_status got %h exp 25", v); end
    bus_peek(A_DATA, v); checks++; if (v !== 8'h11) begin errors++; $display("FAIL ovr_keep got %h exp 11", v); end
    bus_write(A_STAT, 8'h04);
    bus_peek(A_STAT, v); checks++; if (v !== 8'h21) begin errors++; $display("FAIL ovr_w1c got %h exp 21", v); end
    data_pop(v);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v; logic [15:0] rx; logic oe;
    bus_write(A_DUMMY, 8'h5B);
    bus_write(A_DATA, 8'hC3);
    spi_frame({8'h12, 8'h34}, 16, rx, oe);
    checks++; if (rx !== 16'hC35B) begin errors++; $display("FAIL b2b_miso got %h exp c35b", rx); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h25) begin errors++; $display("FAIL b2b_status got %h exp 25", v); end
    bus_write(A_STAT, 8'h04);
    data_pop(v); checks++; if (v !== 8'h12) begin errors++; $display("FAIL b2b_rxdata got %h exp 12", v); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h20) begin errors++; $display("FAIL b2b_clean got %h exp 20", v); end
  endtask

  task automatic test_abort();
    logic [7:0] v; logic [15:0] rx; logic oe;
    spi_frame(16'hA000, 5, rx, oe);
    bus_peek(A_STAT, v); checks++; if (v !== 8'h28) begin errors++; $display("FAIL abort_status got %h exp 28", v); end
    spi_frame({8'h5A, 8'h00}, 8, rx, oe);
    checks++; if (rx[7:0] !== 8'h5B) begin errors++; $display("FAIL abort_dummy got %h exp 5b", rx[7:0]); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h29) begin errors++; $display("FAIL abort_sticky got %h exp 29", v); end
    bus_write(A_STAT, 8'h08);
    bus_peek(A_STAT, v); checks++; if (v !== 8'h21) begin errors++; $display("FAIL abort_w1c got %h exp 21", v); end
    data_pop(v); checks++; if (v !== 8'h5A) begin errors++; $display("FAIL abort_next got %h exp 5a", v); end
  endtask

  task automatic test_en_while_low();
    logic [7:0] v;
    bus_write(A_CTRL, 8'h00);
    @(negedge clk); ss_n = 1'b0;
    wait_clk(8);
    bus_write(A_CTRL, 8'h01);
    wait_clk(8);
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL enlow_oe got %b exp 0", miso_oe); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h00) begin errors++; $display("FAIL enlow_status got %h exp 00", v); end
    ss_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_disabled();
    logic [7:0] v; logic [15:0] rx; logic oe;
    bus_write(A_CTRL, 8'h00);
    spi_frame({8'h77, 8'h00}, 8, rx, oe);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL dis_oe got %b exp 0", oe); end
    checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL dis_miso got %h exp 00", rx[7:0]); end
    bus_peek(A_STAT, v); checks++; if (v !== 8'h20) begin errors++; $display("FAIL dis_status got %h exp 20", v); end
  endtask

  task automatic test_irq();
    logic [7:0] v; logic [15:0] rx; logic oe;
    bus_write(A_CTRL, 8'h03);
`ifdef SPI_SLAVE_IRQ_EN
    bus_peek(A_CTRL, v); checks++; if (v !== 8'h03) begin errors++; $display("FAIL irq_ctrl got %h exp 03", v); end
    spi_frame({8'h80, 8'h00}, 8, rx, oe);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    @(negedge clk); addr = A_DATA; rd_en = 1'b1;
    #1 v = dout;
    @(negedge clk); rd_en = 1'b0;
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL irq_data got %h exp 80", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
`else
    bus_peek(A_CTRL, v); checks++; if (v !== 8'h01) begin errors++; $display("FAIL irq_ctrl got %h exp 01", v); end
    spi_frame({8'h80, 8'h00}, 8, rx, oe);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b exp 0", irq); end
    data_pop(v); checks++; if (v !== 8'h80) begin errors++; $display("FAIL irq_data got %h exp 80", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_decode();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_en_while_low();
    test_disabled();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
